// File: rtl/tiamc1_pkg.sv
// Shared types and constants for the ROM download controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tiamc1_pkg;

   // Download controller FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_READY = 2'd3
   } state_t;

   // HPS transfer indices
   localparam logic [7:0] IDX_ROM = 8'd0;
   localparam logic [7:0] IDX_TNO = 8'd1;

   // Default core reset hold after a download, in clk_sys cycles
   localparam int unsigned RST_HOLD_DEF = 256;

endpackage

// File: rtl/rom_dl_ctrl.sv
// Routes HPS index-0 bytes into the ROM, checks order/range, sums them and sequences core reset.
// Latency: dn_wr/dn_addr/dn_data one cycle after the accepted ioctl_wr; tno one cycle after its strobe.
// Backpressure: none; every HPS byte strobe is consumed (accepted or flagged) in the cycle it arrives.
module rom_dl_ctrl
   import tiamc1_pkg::*;
#(
   parameter int unsigned RST_HOLD = RST_HOLD_DEF,
   parameter int unsigned ROM_SIZE = 32'hC0000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic [7:0]  ioctl_index,
   output logic [19:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        dn_wr,
   output logic [7:0]  tno,
   output logic        core_reset,
   output logic        rom_valid,
   output logic        dl_err,
   output logic [15:0] checksum,
   output logic [1:0]  led_disk
);

   // Expected-address counter must be able to reach ROM_SIZE itself (the "complete" value)
   localparam int AW = $clog2(ROM_SIZE + 1);
   localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   state_t          state;
   logic [AW-1:0]   exp_addr;
   logic [HW-1:0]   hold_cnt;
   logic            led_load;

   logic            rom_strobe;
   logic            in_range;
   logic            in_seq;
   logic            accept;
   logic            reject;
   logic            enter_load;

   assign rom_strobe = ioctl_download && ioctl_wr && (ioctl_index == IDX_ROM);
   assign in_range   = ioctl_addr < 25'(ROM_SIZE);
   assign in_seq     = ioctl_addr == 25'(exp_addr);
   assign accept     = (state == ST_LOAD) && rom_strobe && in_range && in_seq;
   assign reject     = (state == ST_LOAD) && rom_strobe && !(in_range && in_seq);
   // A new ROM transfer restarts loading from any state other than LOAD itself
   assign enter_load = ioctl_download && (ioctl_index == IDX_ROM) && (state != ST_LOAD);

   assign led_disk = {1'b1, led_load};

   // Download FSM with byte forwarding, checksum, error tracking and registered core reset
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         exp_addr   <= '0;
         hold_cnt   <= '0;
         checksum   <= '0;
         dl_err     <= 1'b0;
         rom_valid  <= 1'b0;
         core_reset <= 1'b1;
         led_load   <= 1'b0;
         dn_wr      <= 1'b0;
         dn_addr    <= '0;
         dn_data    <= '0;
      end else begin
         dn_wr <= accept;
         if (accept) begin
            dn_addr  <= ioctl_addr[19:0];
            dn_data  <= ioctl_dout;
            checksum <= checksum + {8'h00, ioctl_dout};
            exp_addr <= exp_addr + 1'b1;
         end
         if (reject) begin
            dl_err <= 1'b1;
         end

         if (enter_load) begin
            state      <= ST_LOAD;
            exp_addr   <= '0;
            checksum   <= '0;
            dl_err     <= 1'b0;
            rom_valid  <= 1'b0;
            core_reset <= 1'b1;
            led_load   <= 1'b1;
         end else begin
            case (state)
               ST_LOAD: begin
                  if (!ioctl_download) begin
                     state    <= ST_HOLD;
                     hold_cnt <= HW'(RST_HOLD - 1);
                     led_load <= 1'b0;
                  end
               end
               ST_HOLD: begin
                  if (hold_cnt == '0) begin
                     state      <= ST_READY;
                     rom_valid  <= !dl_err && (exp_addr == AW'(ROM_SIZE));
                     core_reset <= 1'b0;
                  end else begin
                     hold_cnt <= hold_cnt - 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Title number latch, independent of the ROM FSM
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         tno <= '0;
      end else if (ioctl_download && ioctl_wr && (ioctl_index == IDX_TNO)) begin
         tno <= ioctl_dout;
      end
   end

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Directed bench for rom_dl_ctrl with a 16-byte ROM and a 256-cycle reset hold.
// Latency: n/a.
// Backpressure: n/a.
module tb_rom_dl_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [7:0]  ioctl_index;
   logic [19:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wr;
   logic [7:0]  tno;
   logic        core_reset;
   logic        rom_valid;
   logic        dl_err;
   logic [15:0] checksum;
   logic [1:0]  led_disk;

   int n_run  = 0;
   int n_fail = 0;

   rom_dl_ctrl #(.RST_HOLD(256), .ROM_SIZE(16)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
      .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .tno(tno),
      .core_reset(core_reset), .rom_valid(rom_valid), .dl_err(dl_err),
      .checksum(checksum), .led_disk(led_disk)
   );

   always #5 clk_sys = ~clk_sys;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // One-cycle byte strobe; returns just after the capturing edge
   task automatic strobe(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
      ioctl_index = idx;
      ioctl_addr  = a;
      ioctl_dout  = d;
      ioctl_wr    = 1'b1;
      tick();
      ioctl_wr    = 1'b0;
      ioctl_index = 8'd0;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      n_run++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL rst_core_reset: got %b want 1", core_reset); end
      n_run++; if (led_disk !== 2'b10) begin n_fail++; $display("FAIL rst_led: got %b want 10", led_disk); end
      tick(); tick();
      n_run++; if (dn_wr !== 1'b0 || dn_addr !== 20'h0 || dn_data !== 8'h0) begin n_fail++; $display("FAIL rst_dn: got %b %h %h want 0 0 0", dn_wr, dn_addr, dn_data); end
      n_run++; if (tno !== 8'h0 || checksum !== 16'h0) begin n_fail++; $display("FAIL rst_tno_sum: got %h %h want 0 0", tno, checksum); end
      n_run++; if (dl_err !== 1'b0 || rom_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got err=%b valid=%b want 0 0", dl_err, rom_valid); end
      reset_n = 1'b1;
      repeat (5) tick();
      n_run++; if (core_reset !== 1'b1 || led_disk !== 2'b10) begin n_fail++; $display("FAIL idle_hold: got %b %b want 1 10", core_reset, led_disk); end
   endtask

   task automatic test_download();
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      tick();
      n_run++; if (led_disk !== 2'b11 || core_reset !== 1'b1) begin n_fail++; $display("FAIL dl_enter: got %b %b want 11 1", led_disk, core_reset); end
      for (int i = 0; i < 16; i++) begin
         n_run++; if (dn_wr !== 1'b0) begin n_fail++; $display("FAIL dl_pre_wr[%0d]: got %b want 0", i, dn_wr); end
         strobe(8'd0, 25'(i), 8'(i + 1));
         n_run++; if (dn_wr !== 1'b1 || dn_addr !== 20'(i) || dn_data !== 8'(i + 1)) begin
            n_fail++; $display("FAIL dl_byte[%0d]: got %b %h %h want 1 %h %h", i, dn_wr, dn_addr, dn_data, i, i + 1);
         end
         tick();
      end
      n_run++; if (checksum !== 16'h0088 || dl_err !== 1'b0) begin n_fail++; $display("FAIL dl_sum: got %h err=%b want 0088 0", checksum, dl_err); end
      ioctl_download = 1'b0;
      tick();
      n_run++; if (led_disk !== 2'b10) begin n_fail++; $display("FAIL dl_hold_led: got %b want 10", led_disk); end
      repeat (255) tick();
      n_run++; if (core_reset !== 1'b1 || rom_valid !== 1'b0) begin n_fail++; $display("FAIL dl_hold_end: got %b %b want 1 0", core_reset, rom_valid); end
      tick();
      n_run++; if (core_reset !== 1'b0 || rom_valid !== 1'b1) begin n_fail++; $display("FAIL dl_ready: got %b %b want 0 1", core_reset, rom_valid); end
   endtask

   task automatic test_seq_error();
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      tick();
      n_run++; if (rom_valid !== 1'b0 || checksum !== 16'h0 || core_reset !== 1'b1) begin
         n_fail++; $display("FAIL seq_enter: got %b %h %b want 0 0000 1", rom_valid, checksum, core_reset);
      end
      strobe(8'd0, 25'd0, 8'hA0);
      n_run++; if (dn_wr !== 1'b1) begin n_fail++; $display("FAIL seq_a0: got %b want 1", dn_wr); end
      tick();
      strobe(8'd0, 25'd1, 8'h0B);
      n_run++; if (dn_wr !== 1'b1) begin n_fail++; $display("FAIL seq_a1: got %b want 1", dn_wr); end
      tick();
      strobe(8'd0, 25'd3, 8'h30);
      n_run++; if (dn_wr !== 1'b0 || dl_err !== 1'b1) begin n_fail++; $display("FAIL seq_a3: got %b err=%b want 0 1", dn_wr, dl_err); end
      tick();
      n_run++; if (checksum !== 16'h00AB) begin n_fail++; $display("FAIL seq_sum: got %h want 00ab", checksum); end
      ioctl_download = 1'b0;
      repeat (257) tick();
      n_run++; if (rom_valid !== 1'b0 || dl_err !== 1'b1 || core_reset !== 1'b0) begin
         n_fail++; $display("FAIL seq_ready: got %b %b %b want 0 1 0", rom_valid, dl_err, core_reset);
      end
   endtask

   task automatic test_range();
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      tick();
      n_run++; if (dl_err !== 1'b0) begin n_fail++; $display("FAIL rng_clear: got %b want 0", dl_err); end
      for (int i = 0; i < 16; i++) begin
         strobe(8'd0, 25'(i), 8'h10);
         tick();
      end
      strobe(8'd0, 25'd16, 8'h55);
      n_run++; if (dn_wr !== 1'b0 || dl_err !== 1'b1 || checksum !== 16'h0100) begin
         n_fail++; $display("FAIL rng_a16: got %b %b %h want 0 1 0100", dn_wr, dl_err, checksum);
      end
      tick();
      ioctl_download = 1'b0;
      repeat (257) tick();
      n_run++; if (rom_valid !== 1'b0 || checksum !== 16'h0100) begin n_fail++; $display("FAIL rng_ready: got %b %h want 0 0100", rom_valid, checksum); end
   endtask

   task automatic test_tno_concurrent();
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      tick();
      strobe(8'd0, 25'd0, 8'h21);
      n_run++; if (dn_wr !== 1'b1) begin n_fail++; $display("FAIL tno_b0: got %b want 1", dn_wr); end
      tick();
      strobe(8'd1, 25'd0, 8'h05);
      n_run++; if (tno !== 8'h05 || dn_wr !== 1'b0) begin n_fail++; $display("FAIL tno_latch: got %h %b want 05 0", tno, dn_wr); end
      tick();
      strobe(8'd0, 25'd1, 8'h22);
      n_run++; if (dn_wr !== 1'b1 || dn_addr !== 20'd1 || dn_data !== 8'h22) begin
         n_fail++; $display("FAIL tno_b1: got %b %h %h want 1 00001 22", dn_wr, dn_addr, dn_data);
      end
      tick();
      n_run++; if (checksum !== 16'h0043 || dl_err !== 1'b0) begin n_fail++; $display("FAIL tno_sum: got %h %b want 0043 0", checksum, dl_err); end
   endtask

   task automatic test_reset_mid_load();
      strobe(8'd0, 25'd2, 8'h23);
      n_run++; if (dn_wr !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %b want 1", dn_wr); end
      #2 reset_n = 1'b0;
      #1;
      n_run++; if (dn_wr !== 1'b0 || checksum !== 16'h0 || core_reset !== 1'b1 || led_disk !== 2'b10 || tno !== 8'h0) begin
         n_fail++; $display("FAIL mid_rst: got %b %h %b %b %h want 0 0000 1 10 00", dn_wr, checksum, core_reset, led_disk, tno);
      end
      ioctl_download = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         strobe(8'd0, 25'(i), 8'(i * 3 + 7));
         tick();
      end
      n_run++; if (checksum !== 16'h01D8) begin n_fail++; $display("FAIL mid_sum: got %h want 01d8", checksum); end
      ioctl_download = 1'b0;
      repeat (257) tick();
      n_run++; if (rom_valid !== 1'b1 || core_reset !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b %b want 1 0", rom_valid, core_reset); end
   endtask

   task automatic test_restart_in_hold();
      int low_cycles;
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         strobe(8'd0, 25'(i), 8'h01);
         tick();
      end
      ioctl_download = 1'b0;
      low_cycles = 0;
      tick();
      for (int i = 0; i < 155; i++) begin
         tick();
         if (core_reset !== 1'b1) low_cycles++;
      end
      ioctl_download = 1'b1;
      tick();
      n_run++; if (led_disk !== 2'b11 || checksum !== 16'h0 || rom_valid !== 1'b0) begin
         n_fail++; $display("FAIL rs_enter: got %b %h %b want 11 0000 0", led_disk, checksum, rom_valid);
      end
      for (int i = 0; i < 200; i++) begin
         tick();
         if (core_reset !== 1'b1) low_cycles++;
      end
      n_run++; if (low_cycles !== 0) begin n_fail++; $display("FAIL rs_core_reset: got %0d low cycles want 0", low_cycles); end
   endtask

   task automatic test_ignored();
      strobe(8'd0, 25'd0, 8'h11);
      n_run++; if (dn_wr !== 1'b1) begin n_fail++; $display("FAIL ign_b0: got %b want 1", dn_wr); end
      tick();
      strobe(8'd2, 25'd1, 8'h22);
      n_run++; if (dn_wr !== 1'b0 || tno !== 8'h00 || dl_err !== 1'b0) begin
         n_fail++; $display("FAIL ign_idx2: got %b %h %b want 0 00 0", dn_wr, tno, dl_err);
      end
      tick();
      ioctl_download = 1'b0;
      tick();
      strobe(8'd0, 25'd1, 8'h33);
      n_run++; if (dn_wr !== 1'b0) begin n_fail++; $display("FAIL ign_nodl_rom: got %b want 0", dn_wr); end
      strobe(8'd1, 25'd0, 8'h77);
      n_run++; if (tno !== 8'h00 || checksum !== 16'h0011) begin n_fail++; $display("FAIL ign_nodl_tno: got %h %h want 00 0011", tno, checksum); end
   endtask

   initial begin
      reset_n        = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      ioctl_index    = '0;
      test_reset();
      test_download();
      test_seq_error();
      test_range();
      test_tno_concurrent();
      test_reset_mid_load();
      test_restart_in_hold();
      test_ignored();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
